// File: rtl/apb_slave_bank.sv
// ============================================================================
// Module      : apb_slave_bank
// Description : APB completer with NUM_SLAVES register banks (one per Pselx
//               bit), programmable wait states, error and abort reporting.
//               Optional byte-strobe writes are enabled by macro APB_PSTRB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_slave_bank #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int NUM_SLAVES  = 3,
    parameter int WORDS       = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  Hclk,
    input  logic                  Hreset,
    input  logic [NUM_SLAVES-1:0] Pselx,
    input  logic                  Penable,
    input  logic                  Pwrite,
    input  logic [ADDR_W-1:0]     Paddr,
    input  logic [DATA_W-1:0]     Pwdata,
`ifdef APB_PSTRB_EN
    input  logic [DATA_W/8-1:0]   Pstrb,
`endif
    output logic [DATA_W-1:0]     Prdata,
    output logic                  Pready,
    output logic                  Pslverr,
    output logic                  Pproterr
);

    localparam int c_IDX_W  = $clog2(WORDS);
    localparam int c_BANK_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int c_NBYTES = DATA_W / 8;
    localparam logic [3:0] c_WAIT = 4'(WAIT_CYCLES);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_WAIT   = 2'd1;
    localparam logic [1:0] c_ST_ACCESS = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [3:0]            r_cnt;
    logic [NUM_SLAVES-1:0] r_sel;
    logic                  r_write;
    logic [c_IDX_W-1:0]    r_idx;
    logic [c_BANK_W-1:0]   r_bank;
    logic                  r_err;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_pproterr;
    logic [DATA_W-1:0]     r_mem [NUM_SLAVES][WORDS];

    logic                  w_setup;
    logic                  w_same;
    logic                  w_err;
    logic                  w_abort;
    logic                  w_commit;
    logic [c_BANK_W-1:0]   w_bank;
    logic [c_IDX_W-1:0]    w_idx;
    logic [c_NBYTES-1:0]   w_wmask;

    assign w_setup = (|Pselx) && !Penable;
    assign w_same  = Penable && (Pselx == r_sel);
    assign w_idx   = Paddr[c_IDX_W+1:2];

    // Not one-hot, misaligned, or beyond the bank's address window.
    assign w_err = ((Pselx & (Pselx - NUM_SLAVES'(1))) != '0)
                || (Paddr[1:0] != 2'b00)
                || ((Paddr >> (c_IDX_W + 2)) != '0);

    always_comb begin
        w_bank = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (Pselx[i]) w_bank = c_BANK_W'(i);
        end
    end

`ifdef APB_PSTRB_EN
    assign w_wmask = Pstrb;
`else
    assign w_wmask = '1;
`endif

    // State register
    always_ff @(posedge Hclk) begin
        if (Hreset) r_state <= c_ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_setup) w_next_state = (WAIT_CYCLES == 0) ? c_ST_ACCESS : c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (!w_same)              w_next_state = c_ST_IDLE;
                else if (r_cnt == c_WAIT) w_next_state = c_ST_ACCESS;
            end
            c_ST_ACCESS: w_next_state = c_ST_IDLE;
            default:     w_next_state = c_ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        Pready   = (r_state == c_ST_ACCESS);
        Pslverr  = Pready && r_err;
        Prdata   = (Pready && !r_write && !r_err) ? r_rdata : '0;
        w_abort  = ((r_state == c_ST_WAIT) || (r_state == c_ST_ACCESS)) && !w_same;
        w_commit = Pready && w_same && r_write && !r_err;
    end

    assign Pproterr = r_pproterr;

    // Transfer context, read capture and bank storage
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_cnt      <= '0;
            r_sel      <= '0;
            r_write    <= 1'b0;
            r_idx      <= '0;
            r_bank     <= '0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_pproterr <= 1'b0;
            for (int b = 0; b < NUM_SLAVES; b++) begin
                for (int w = 0; w < WORDS; w++) begin
                    r_mem[b][w] <= '0;
                end
            end
        end else begin
            r_pproterr <= w_abort;
            if ((r_state == c_ST_IDLE) && w_setup) begin
                r_sel   <= Pselx;
                r_write <= Pwrite;
                r_idx   <= w_idx;
                r_bank  <= w_bank;
                r_err   <= w_err;
                r_cnt   <= 4'd1;
                if (!Pwrite && !w_err) r_rdata <= r_mem[w_bank][w_idx];
            end else if ((r_state == c_ST_WAIT) && w_same) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_commit) begin
                for (int k = 0; k < c_NBYTES; k++) begin
                    if (w_wmask[k]) r_mem[r_bank][r_idx][k*8 +: 8] <= Pwdata[k*8 +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/apb_slave_bank.md
Name: apb_slave_bank

Overview:
- Parametrised APB completer that replaces the combinational pass-through/random-data slave model on the APB side of the AHB2APB bridge.
- Provides NUM_SLAVES independent register banks, one per Pselx bit, with real storage.
- Adds programmable wait states (Pready), error response (Pslverr) and protocol-abort detection.
- Used as the bridge's APB-side target in integration benches.

Parameters:
- DATA_W, 32, Pwdata/Prdata width (multiple of 8)
- ADDR_W, 32, Paddr width
- NUM_SLAVES, 3, number of Pselx lines and banks
- WORDS, 16, words per bank (power of 2, >=2); IDX_W = log2(WORDS)
- WAIT_CYCLES, 0, Pready-low cycles per access (0..15)

Ports:
- Hclk  in  1  single clock
- Hreset  in  1  synchronous, active-high reset
- Pselx  in  NUM_SLAVES  slave selects
- Penable  in  1  access phase
- Pwrite  in  1  1=write, 0=read
- Paddr  in  ADDR_W  byte address
- Pwdata  in  DATA_W  write data
- Prdata  out  DATA_W  read data, valid only while Pready=1 and read
- Pready  out  1  transfer complete
- Pslverr  out  1  error, valid only while Pready=1
- Pproterr  out  1  one-cycle pulse on protocol abort

Behaviour:
- Clock and reset: one clock Hclk; reset Hreset is synchronous, active-high.
- Reset values: state=IDLE, counter=0, all bank words=0, Prdata=0, Pready=0, Pslverr=0, Pproterr=0. Reset mid-transfer abandons it with no write and no Pproterr.
- States: IDLE, WAIT, ACCESS.
- IDLE:
  - Setup sampled when |Pselx and !Penable.
  - At that edge, latch sel, Pwrite, word index Paddr[IDX_W+1:2] and error flag.
  - Error flag is set if Pselx is not one-hot, Paddr[1:0]!=0, or Paddr[ADDR_W-1:IDX_W+2]!=0.
  - For an error-free read, latch bank word into rdata_q.
  - Next state: ACCESS if WAIT_CYCLES==0, else WAIT with counter=1.
  - Penable=1 while in IDLE: ignored, no pulse.
- WAIT:
  - Pready=0.
  - If Penable=1 and Pselx unchanged: counter++. Go to ACCESS when counter==WAIT_CYCLES at the edge.
  - Otherwise (abort): go to IDLE, Pproterr=1 for one cycle.
- ACCESS:
  - Pready=1 combinationally from state.
  - Pslverr = latched error.
  - Prdata = rdata_q when read and no error; 0 otherwise.
  - At the edge: if Penable=1 and Pselx unchanged, commit an error-free write to bank[sel][idx] and go to IDLE.
  - If Penable or Pselx dropped: go to IDLE, no write, Pproterr pulse.
- Latency: zero-wait transfer is 2 cycles (setup + access). Each transfer takes 2+WAIT_CYCLES cycles.
- Back-to-back: the next SETUP is sampled in the IDLE cycle right after ACCESS.
- Read-after-write to the same word returns the new data, since the write commits before the next setup edge.
- Error transfers never modify storage.
- Pready, Pslverr and Prdata are 0 in IDLE and WAIT.

Optional Feature:
- Macro: APB_PSTRB_EN.
- Defined:
  - Adds input Pstrb, DATA_W/8 bits.
  - A write updates only bytes whose strobe bit is 1.
  - Pstrb is ignored on reads.
  - A write with Pstrb all zero completes with Pready=1, Pslverr=0 and no storage change.
- Undefined:
  - Port is absent.
  - Every write updates the full word.

Test Plan:
- WAIT_CYCLES=0: write 0xDEADBEEF to Pselx=3'b001, Paddr=0x8, then read the same -> Pready high on the 2nd cycle of each transfer, Prdata=0xDEADBEEF, Pslverr=0. A read of bank 1 at Paddr=0x8 returns 0.
- WAIT_CYCLES=2: read Pselx=3'b100, Paddr=0x0 -> Pready low for 2 Penable cycles, high on the 3rd, Prdata=0.
- Errors:
  - Pselx=3'b011 write 0x1234 at Paddr 0x4 -> Pslverr=1 with Pready, no bank changes.
  - Paddr=0x6 -> Pslverr=1.
  - Paddr=0x40 (WORDS=16) -> Pslverr=1.
- Abort: WAIT_CYCLES=3, drop Penable after 1 wait cycle of a write of 0xA5A5A5A5 -> Pproterr pulses 1 cycle, state IDLE, subsequent read returns the old value.
- Reset: assert Hreset in the ACCESS cycle of a write -> word stays 0, outputs 0 the next cycle.
- APB_PSTRB_EN: word = 0x11223344, write 0xAABBCCDD with Pstrb=4'b0101 -> read 0x11BB33DD.
